// File: rtl/axis_bit_packer.sv
// axis_bit_packer: packs variable-length codewords into fixed W-bit AXI-Stream words, with end-of-stream flush
// Ports:
//   clk, rst                     clock; asynchronous active-low reset
//   input_data/length/last/valid codeword (right-aligned), bit count, stream end, valid
//   input_ready                  accept strobe (combinational on output_ready)
//   output_data/last/padding     packed word, final-word flag, zero pad bits in final word
//   output_valid, output_ready   output handshake
module axis_bit_packer #(
  parameter int MAX_CODE_WIDTH = 39,
  parameter int OUTPUT_WIDTH_LOG = 5,
  parameter bit MSB_FIRST = 1,
  parameter int LENGTH_WIDTH = $clog2(MAX_CODE_WIDTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [MAX_CODE_WIDTH-1:0]     input_data,
  input  logic [LENGTH_WIDTH-1:0]       input_length,
  input  logic                          input_last,
  input  logic                          input_valid,
  output logic                          input_ready,
  output logic [2**OUTPUT_WIDTH_LOG-1:0] output_data,
  output logic                          output_last,
  output logic [OUTPUT_WIDTH_LOG:0]     output_padding,
  output logic                          output_valid,
  input  logic                          output_ready
);
  localparam int W = 2**OUTPUT_WIDTH_LOG;
  localparam int BUF = W + MAX_CODE_WIDTH - 1;
  localparam int CW = $clog2(BUF + 1);
  localparam int PW = OUTPUT_WIDTH_LOG + 1;
  localparam logic [CW-1:0] WC = CW'(W);
  localparam logic [CW-1:0] BC = CW'(BUF);
  localparam logic [CW-1:0] MC = CW'(MAX_CODE_WIDTH);
  typedef enum logic {FILL, FLUSH} state_t;
  state_t state, state_n;
  logic [BUF-1:0] bits, bits_d, bits_n;
  logic [CW-1:0] count, cnt_d, count_n, len;
  logic [MAX_CODE_WIDTH-1:0] code, code_m, code_r;
  logic [W-1:0] word;
  logic out_fire, in_fire;
  // The buffer always holds the stream oldest-bit-first from the top; LSB-first
  // mode only reverses each code on entry and each word on exit.
  always_comb begin
    len = (input_length > LENGTH_WIDTH'(MAX_CODE_WIDTH)) ? MC : CW'(input_length);
    code_m = input_data & ~({MAX_CODE_WIDTH{1'b1}} << len);
    for (int i = 0; i < MAX_CODE_WIDTH; i++) code_r[i] = code_m[MAX_CODE_WIDTH-1-i];
    code = MSB_FIRST ? code_m : code_r >> (MC - len);
    word = bits[BUF-1 -: W];
    for (int i = 0; i < W; i++) output_data[i] = MSB_FIRST ? word[i] : word[W-1-i];
  end
  assign output_valid = state == FLUSH || count >= WC;
  assign output_last = state == FLUSH && count <= WC;
  assign output_padding = output_last ? PW'(WC - count) : '0;
  assign out_fire = output_valid && output_ready;
  assign cnt_d = out_fire ? count - WC : count;
  // rst gating keeps ready low while reset is held, since the registers alone would raise it
  assign input_ready = rst && state == FILL && cnt_d < WC;
  assign in_fire = input_valid && input_ready;
  always_comb begin
    bits_d = out_fire ? bits << W : bits;
    state_n = state;
    bits_n = bits_d;
    count_n = cnt_d;
    if (in_fire) begin
      bits_n = bits_d | ({{(BUF-MAX_CODE_WIDTH){1'b0}}, code} << (BC - cnt_d - len));
      count_n = cnt_d + len;
      state_n = input_last ? FLUSH : FILL;
    end
    // the final flush word empties the buffer regardless of how many bits it carried
    if (state == FLUSH && out_fire && count <= WC) begin
      state_n = FILL;
      count_n = '0;
      bits_n = '0;
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= FILL;
      count <= '0;
      bits <= '0;
    end else begin
      state <= state_n;
      count <= count_n;
      bits <= bits_n;
    end
endmodule

// File: tb/tb_axis_bit_packer.sv
// tb_axis_bit_packer: directed checks of MSB-first and LSB-first packers driven in parallel
module tb_axis_bit_packer;
  logic clk = 0, rst = 0;
  logic [38:0] input_data = '0;
  logic [5:0] input_length = '0;
  logic input_last = 0, input_valid = 0, output_ready = 1;
  logic ir_m, ol_m, ov_m, ir_l, ol_l, ov_l;
  logic [31:0] od_m, od_l;
  logic [5:0] op_m, op_l;
  int checks = 0, errs = 0;
  always #5 clk = ~clk;
  axis_bit_packer u_msb (
    .clk(clk), .rst(rst), .input_data(input_data), .input_length(input_length),
    .input_last(input_last), .input_valid(input_valid), .input_ready(ir_m),
    .output_data(od_m), .output_last(ol_m), .output_padding(op_m),
    .output_valid(ov_m), .output_ready(output_ready)
  );
  axis_bit_packer #(.MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst(rst), .input_data(input_data), .input_length(input_length),
    .input_last(input_last), .input_valid(input_valid), .input_ready(ir_l),
    .output_data(od_l), .output_last(ol_l), .output_padding(op_l),
    .output_valid(ov_l), .output_ready(output_ready)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [38:0] d, input logic [5:0] l, input logic last);
    int n = 0;
    input_data = d;
    input_length = l;
    input_last = last;
    input_valid = 1;
    @(negedge clk);
    while (!ir_m && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept", ir_m, 1);
    @(posedge clk);
    #1 input_valid = 0;
  endtask
  task automatic expect_word(input string tag, input logic [31:0] m, input logic [31:0] l,
                             input logic last, input logic [5:0] pad);
    chk({tag, "_valid"}, ov_m, 1);
    chk({tag, "_data_msb"}, od_m, m);
    chk({tag, "_data_lsb"}, od_l, l);
    chk({tag, "_last"}, ol_m, last);
    chk({tag, "_last_lsb"}, ol_l, last);
    chk({tag, "_pad"}, op_m, pad);
    chk({tag, "_pad_lsb"}, op_l, pad);
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", ov_m, 0);
    chk("rst_data", od_m, 0);
    chk("rst_ready", ir_m, 0);
    rst = 1;
    #1 chk("post_rst_ready", ir_m, 1);
    chk("post_rst_ready_lsb", ir_l, 1);
    send(39'hA1, 8, 0);
    send(39'hB2, 8, 0);
    send(39'hC3, 8, 0);
    send(39'hD4, 8, 1);
    expect_word("four_bytes", 32'hA1B2C3D4, 32'hD4C3B2A1, 1, 0);
    cyc;
    chk("four_bytes_done", ov_m, 0);
    send(39'h5, 3, 1);
    expect_word("short_last", 32'hA0000000, 32'h00000005, 1, 29);
    cyc;
    send(39'h7F_FFFF_FFFF, 39, 0);
    expect_word("spill_full", 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    send(39'h0, 25, 1);
    expect_word("spill_tail", 32'hFE000000, 32'h0000007F, 1, 0);
    chk("spill_ready_low", ir_m, 0);
    cyc;
    chk("spill_ready_back", ir_m, 1);
    chk("spill_done", ov_m, 0);
    output_ready = 0;
    send(39'h1, 1, 0);
    send(39'hAB, 39, 0);
    chk("bp_data", od_m, 32'h80000000);
    chk("bp_data_lsb", od_l, 32'h00000157);
    input_data = 39'hCD;
    input_length = 8;
    input_last = 0;
    input_valid = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_ready_low", ir_m, 0);
      chk("bp_valid_hold", ov_m, 1);
      chk("bp_data_stable", od_m, 32'h80000000);
    end
    @(posedge clk);
    #1 output_ready = 1;
    @(negedge clk);
    chk("bp_drain_fill_ready", ir_m, 1);
    @(posedge clk);
    #1 input_valid = 0;
    chk("bp_after_drain", ov_m, 0);
    send(39'hEF, 8, 1);
    expect_word("bp_tail", 32'hABCDEF00, 32'h00EFCD00, 1, 8);
    cyc;
    send(39'h1, 1, 0);
    send(39'h7, 0, 0);
    send(39'h3, 2, 1);
    expect_word("bits3", 32'hE0000000, 32'h00000007, 1, 29);
    cyc;
    send(39'h0, 0, 1);
    expect_word("empty", 32'h0, 32'h0, 1, 32);
    cyc;
    chk("empty_done", ov_m, 0);
    output_ready = 0;
    send(39'h123, 12, 1);
    chk("flush_pending", ov_m, 1);
    #2 rst = 0;
    #1;
    chk("arst_valid", ov_m, 0);
    chk("arst_data", od_m, 0);
    chk("arst_last", ol_m, 0);
    chk("arst_pad", op_m, 0);
    chk("arst_ready", ir_m, 0);
    chk("arst_valid_lsb", ov_l, 0);
    #3 rst = 1;
    output_ready = 1;
    send(39'hFF, 8, 1);
    expect_word("after_rst", 32'hFF000000, 32'h000000FF, 1, 24);
    cyc;
    chk("after_rst_done", ov_m, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end
endmodule

// File: doc/axis_bit_packer.md
# axis_bit_packer

Parametrised AXI-Stream bit packer that concatenates variable-length codewords into fixed 2**OUTPUT_WIDTH_LOG-bit output words. It sits at the tail of the CODER datapath, after the Golomb / exp-zero stages, and feeds the compressed-stream output port. It adds selectable bit order, codes wider than the output word, and end-of-image flush with zero padding and a reported padding count.

## Interface
- MAX_CODE_WIDTH, 39: widest accepted codeword, in bits; may exceed 2**OUTPUT_WIDTH_LOG.
- OUTPUT_WIDTH_LOG, 5: output word width W = 2**OUTPUT_WIDTH_LOG.
- MSB_FIRST, 1: 1 packs from output bit W-1 downward; 0 packs from bit 0 upward.
- LENGTH_WIDTH, $clog2(MAX_CODE_WIDTH+1): width of the length field (derived).

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; one clock, reset is asynchronous and active-low.
- input_data  in  MAX_CODE_WIDTH  codeword, right-aligned; bits at or above input_length are ignored.
- input_length  in  LENGTH_WIDTH  number of valid bits, 0..MAX_CODE_WIDTH; larger values saturate to MAX_CODE_WIDTH.
- input_last  in  1  marks the final codeword of the stream; triggers flush.
- input_valid  in  1  AXIS valid.
- input_ready  out  1  AXIS ready.
- output_data  out  W  packed word.
- output_last  out  1  marks the final word of the stream.
- output_padding  out  OUTPUT_WIDTH_LOG+1  count of zero pad bits in the word; nonzero only when output_last=1.
- output_valid  out  1  AXIS valid.
- output_ready  in  1  AXIS ready.

## Operation
- Bit buffer: BUF = W+MAX_CODE_WIDTH-1 bits. Counter `count` ranges 0..BUF.
- Codeword bit order:
  - MSB_FIRST=1: code bit length-1 is emitted first and lands at the highest free position.
  - MSB_FIRST=0: code bit 0 is emitted first and lands at the lowest free position.
- Output word: the oldest W bits of the buffer. Unfilled positions read as 0.
- States:
  - FILL (reset state):
    - output_valid = (count >= W).
    - input_ready = ((count - (out_fire ? W : 0)) < W).
  - FLUSH:
    - Entered on accepting a code with input_last=1.
    - input_ready = 0.
    - output_valid = 1 while count > 0, or while an empty-stream word is pending.
- In FLUSH, the word whose handshake drains count to 0 carries output_last=1 and output_padding = W - bits_in_word. The state then returns to FILL with count=0.
- Empty last: input_last with count=0 and length 0 emits one all-zero word with output_last=1 and output_padding=W.
- Zero-length code without last: accepted; no state change.
- Simultaneous input and output handshake in one cycle:
  - Remove W bits first, then append the new code.
  - count_next = count - W + length.
- Reset (async, mid-operation included): count=0, state=FILL, buffer cleared. All outputs drop immediately to 0: output_valid, output_data, output_last, output_padding and input_ready. Any partial stream is discarded.

## Timing
- input_ready depends combinationally on output_ready (same-cycle drain-and-fill). output_valid, output_data, output_last and output_padding are driven from registers only.
- Latency: a code accepted in cycle n that completes a word gives output_valid=1 in cycle n+1.
- Throughput:
  - One code per cycle while output_ready=1 and length <= W.
  - A code with length > W produces two words and stalls input for at most one cycle.
- Flush: partial word valid one cycle after the last code is accepted, or after the preceding full word drains.
- AXIS rules:
  - output_data, output_last and output_padding hold stable while output_valid=1 and output_ready=0.
  - output_valid never deasserts without a handshake.
  - input_valid is not required to wait for input_ready.

## Test plan
- MSB_FIRST=1, W=32: codes 0xA1, 0xB2, 0xC3, 0xD4 (len 8), last on the 4th -> one word 0xA1B2C3D4, last=1, padding=0, valid in the cycle after the 4th accept.
- Code 0x5 len 3 with last -> 0xA0000000, last=1, padding=29.
- Spill: 39 ones, then 25 zeros with last -> 0xFFFFFFFF, then 0xFE000000 with last=1, padding=0. input_ready low for exactly one cycle.
- Backpressure: with count >= 32, hold output_ready=0 for 5 cycles -> input_ready=0 and output_data stable throughout; with output_ready=1 and count=40, a new len-8 code is accepted in the same cycle as the drain.
- MSB_FIRST=0: 0x1 len 1, then 0x3 len 2 with last -> 0x00000007, last=1, padding=29. Empty last (len 0, count 0) -> 0x00000000, padding=32.
- Pull rst low mid-FLUSH -> all outputs are 0 in the same cycle. After release, a new stream 0xFF len 8 with last -> 0xFF000000, padding=24, with no residue from the aborted stream.
